adc_rate_ctrl: RTL
==================

Name: adc_rate_ctrl

Overview:
Sample-rate scheduler for the SPI ADC acquisition path in the 10 MHz domain. It holds the active sample period in clk_10m cycles and issues one conv_start strobe per period to the SPI ADC reader. It tracks each conversion through adc_done and flags overruns. It accepts run-time period changes through a valid/ready handshake and applies them glitch-free at a period boundary, so the rate never changes mid-period.

Parameters:
CNT_W, 32, width of period counter, cfg_div and active_div
MIN_DIV, 16, minimum legal period in cycles; smaller requests are clamped up to it
DEFAULT_DIV, 1000, period after reset (10 kHz at 10 MHz)
BURST_W, 16, width of burst_len and sample_cnt

Ports:
clk_10m  in  1  system clock, 10 MHz
rst  in  1  reset; one clock domain (clk_10m); reset is synchronous and active-high
start  in  1  pulse; begin acquisition
stop  in  1  pulse; end acquisition after the outstanding conversion
burst_len  in  BURST_W  conversions per run; 0 = continuous; latched on start
cfg_valid  in  1  new period request
cfg_div  in  CNT_W  requested period in cycles
cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
conv_start  out  1  1-cycle pulse to the SPI ADC reader
adc_done  in  1  1-cycle pulse when the reader finishes a conversion
busy  out  1  state != IDLE
active_div  out  CNT_W  period currently in force
sample_cnt  out  BURST_W  completed conversions in this run
overrun  out  1  sticky; a period elapsed while a conversion was still outstanding
ovr_clr  in  1  clears overrun
done  out  1  1-cycle pulse on return to IDLE from RUN/DRAIN

Behaviour:
- Reset values: state IDLE, cnt 0, conv_start 0, cfg_ready 1, busy 0, active_div DEFAULT_DIV, pending flag 0, sample_cnt 0, overrun 0, done 0, outstanding 0, issued 0. Reset in any state aborts the run immediately. No done pulse is generated on reset.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start && !stop: RUN; latch burst_len; clear sample_cnt and issued; cnt <= 0.
  - conv_start is high in the first cycle after the start edge (latency 1).
  - start && stop in the same cycle: stay IDLE.
- RUN, period tick:
  - cnt counts 0..active_div-1 and wraps. A tick occurs on the cycle cnt == active_div-1; the next cycle is a period start.
  - At a period start with outstanding == 0: conv_start = 1, outstanding <= 1, issued++.
  - At a period start with outstanding == 1: no conv_start, overrun <= 1, issued unchanged (the conversion is skipped, not queued).
- adc_done:
  - Clears outstanding and increments sample_cnt. sample_cnt saturates at all-ones.
  - Ignored when outstanding == 0.
  - If adc_done and a period start coincide, adc_done is processed first: no overrun, and conv_start is issued.
- Burst end: when burst_len != 0 and issued reaches burst_len, go to DRAIN at that same period start. stop in RUN also goes to DRAIN.
- DRAIN:
  - No conv_start is issued.
  - Move to IDLE on the cycle after outstanding == 0, either already clear or cleared by adc_done. done is a 1-cycle pulse on that transition.
  - stop and start are ignored.
- Period update:
  - In IDLE, an accepted request writes active_div on the next edge.
  - In RUN/DRAIN, an accepted request is stored as pending and cfg_ready drops to 0 until it is applied. It is applied at the first tick strictly after acceptance: active_div is updated and cnt restarts at 0 with the new period.
  - Clamp: value = max(cfg_div, MIN_DIV). The comparison is unsigned and full CNT_W wide.
- overrun: set has priority over ovr_clr in the same cycle.
- All outputs are registered.

Decomposition:
- Package adc_rate_pkg: state enum (IDLE, RUN, DRAIN), CNT_W, BURST_W, MIN_DIV, DEFAULT_DIV.
- One natural sub-module, adc_period_timer: the period counter, the pending/active period register with clamp, and the tick output. The FSM, conversion tracking and counters stay in the top.

Test Plan:
- Reset, then start with burst_len = 3 and adc_done 20 cycles after each conv_start -> conv_start at cycles 1, 1001 and 2001 after start; sample_cnt = 3; done pulse one cycle after the third adc_done; busy = 0 afterwards.
- Continuous run with active_div = 100; cfg_div = 50 accepted at cnt = 30 -> the next conv_start is still 100 cycles after the previous one, subsequent ones are 50 apart, and cfg_ready is low until the update applies.
- cfg_div = 5 in IDLE -> active_div = 16, and conv_start pulses are spaced 16 cycles apart.
- active_div = 100 with adc_done withheld for 150 cycles -> the second conv_start is suppressed, overrun = 1 and stays set; ovr_clr clears it; the third period starts normally.
- stop while a conversion is outstanding -> DRAIN with no further conv_start; done on the cycle after adc_done; an adc_done arriving later is ignored.
- rst asserted mid-RUN -> the next cycle shows all outputs at reset values, active_div = 1000, and no done pulse.

Source files
------------

// File: rtl/adc_rate_pkg.sv
// ---------------------------------------------------------------------------
// adc_rate_pkg
// Shared definitions for the SPI ADC sample-rate scheduler.
//   CNT_W       : width of the period counter and of every period value
//   BURST_W     : width of the burst length and completed-sample counter
//   MIN_DIV     : shortest period the scheduler will run; shorter requests
//                 are raised to this value
//   DEFAULT_DIV : period in force after reset (10 kHz at 10 MHz)
//   state_e     : scheduler FSM states
//   clamp_div   : raises a requested period to MIN_DIV (unsigned compare)
//   sat_inc     : saturating increment for burst-width counters
// ---------------------------------------------------------------------------
package adc_rate_pkg;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  localparam logic [CNT_W-1:0] MIN_DIV     = CNT_W'(16);
  localparam logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(1000);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Full-width unsigned compare so that huge requests are never mistaken
  // for small ones.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // Counters built with this stop at all-ones instead of wrapping to zero.
  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
    return (v == '1) ? v : v + BURST_W'(1);
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// ---------------------------------------------------------------------------
// adc_period_timer
// Period counter plus the active/pending period registers for adc_rate_ctrl.
// While the scheduler is idle the counter is held at zero and an accepted
// period request takes effect on the next edge. While a run is in progress a
// request is parked as pending (cfg_ready drops) and only swapped in at the
// end of a period, so a period is never cut short or stretched mid-way.
//
// Ports:
//   clk_10m      : 10 MHz clock
//   rst          : synchronous active-high reset
//   run_i        : high while the scheduler is in RUN or DRAIN
//   cfg_valid_i  : new period request
//   cfg_div_i    : requested period in clock cycles
//   tick_o       : high on the last cycle of a period (cnt == active_div-1)
//   active_div_o : period currently in force
//   cfg_ready_o  : request accepted when cfg_valid_i && cfg_ready_o
// ---------------------------------------------------------------------------
module adc_period_timer
  import adc_rate_pkg::*;
(
  input  logic             clk_10m,
  input  logic             rst,
  input  logic             run_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] active_div_o,
  output logic             cfg_ready_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] active_div_q;
  logic [CNT_W-1:0] pending_div_q;
  logic             pending_q;
  logic             cfg_ready_q;

  logic             accept;
  logic             at_end;
  logic [CNT_W-1:0] req_div;

  // Handshake, clamp and end-of-period decode. active_div never drops below
  // MIN_DIV, so the subtraction cannot underflow.
  assign accept  = cfg_valid_i && cfg_ready_q;
  assign req_div = clamp_div(cfg_div_i);
  assign at_end  = (cnt_q == (active_div_q - CNT_W'(1)));
  assign tick_o  = run_i && at_end;

  // Counter and period registers. When idle the counter sits at zero so a
  // new run always begins with a full period. A pending value is applied
  // only at a tick seen after the acceptance edge (pending_q is not yet set
  // on the acceptance cycle itself), and the wrap to zero on that tick
  // starts the first period at the new length. A value still pending when
  // the run ends is applied straight away so the handshake never stalls.
  always_ff @(posedge clk_10m) begin
    if (rst) begin
      cnt_q         <= '0;
      active_div_q  <= DEFAULT_DIV;
      pending_div_q <= DEFAULT_DIV;
      pending_q     <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else if (!run_i) begin
      cnt_q <= '0;
      if (pending_q) begin
        active_div_q <= pending_div_q;
        pending_q    <= 1'b0;
        cfg_ready_q  <= 1'b1;
      end else if (accept) begin
        active_div_q <= req_div;
      end
    end else begin
      cnt_q <= at_end ? '0 : cnt_q + CNT_W'(1);
      if (pending_q && at_end) begin
        active_div_q <= pending_div_q;
        pending_q    <= 1'b0;
        cfg_ready_q  <= 1'b1;
      end else if (accept) begin
        pending_div_q <= req_div;
        pending_q     <= 1'b1;
        cfg_ready_q   <= 1'b0;
      end
    end
  end

  assign active_div_o = active_div_q;
  assign cfg_ready_o  = cfg_ready_q;

endmodule

// File: rtl/adc_rate_ctrl.sv
// ---------------------------------------------------------------------------
// adc_rate_ctrl
// Sample-rate scheduler for the SPI ADC acquisition path (clk_10m domain).
// Issues one conv_start per period, tracks the single outstanding conversion
// through adc_done, flags overruns when a period elapses before the reader
// finishes, and supports finite bursts or continuous acquisition.
//
// Ports:
//   clk_10m    : 10 MHz clock
//   rst        : synchronous active-high reset, aborts any run
//   start      : pulse, begin acquisition (ignored together with stop)
//   stop       : pulse, finish after the outstanding conversion
//   burst_len  : conversions per run, 0 = continuous; latched on start
//   cfg_valid  : new period request
//   cfg_div    : requested period in cycles (raised to MIN_DIV if smaller)
//   cfg_ready  : request accepted when cfg_valid && cfg_ready
//   conv_start : 1-cycle pulse to the SPI ADC reader
//   adc_done   : 1-cycle pulse when the reader finishes a conversion
//   busy       : high whenever the scheduler is not idle
//   active_div : period currently in force
//   sample_cnt : completed conversions this run (saturating)
//   overrun    : sticky, a period elapsed with a conversion outstanding
//   ovr_clr    : clears overrun (a same-cycle set wins)
//   done       : 1-cycle pulse on return to IDLE from RUN/DRAIN
// ---------------------------------------------------------------------------
module adc_rate_ctrl
  import adc_rate_pkg::*;
(
  input  logic               clk_10m,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  output logic               conv_start,
  input  logic               adc_done,
  output logic               busy,
  output logic [CNT_W-1:0]   active_div,
  output logic [BURST_W-1:0] sample_cnt,
  output logic               overrun,
  input  logic               ovr_clr,
  output logic               done
);

  state_e             state_q;
  logic [BURST_W-1:0] burst_len_q;
  logic [BURST_W-1:0] issued_q;
  logic [BURST_W-1:0] sample_cnt_q;
  logic               outstanding_q;
  logic               conv_start_q;
  logic               busy_q;
  logic               overrun_q;
  logic               done_q;

  logic               tick;
  logic               done_ack_d;
  logic [BURST_W-1:0] issued_d;
  logic [BURST_W-1:0] sample_cnt_d;

  // The timer runs whenever the scheduler is busy; busy_q tracks state_q
  // exactly, so it doubles as the run enable.
  adc_period_timer u_timer (
    .clk_10m      (clk_10m),
    .rst          (rst),
    .run_i        (busy_q),
    .cfg_valid_i  (cfg_valid),
    .cfg_div_i    (cfg_div),
    .tick_o       (tick),
    .active_div_o (active_div),
    .cfg_ready_o  (cfg_ready)
  );

  // An adc_done only counts when a conversion is actually outstanding;
  // stray pulses are dropped here.
  assign done_ack_d   = adc_done && outstanding_q;
  assign issued_d     = sat_inc(issued_q);
  assign sample_cnt_d = sat_inc(sample_cnt_q);

  // Scheduler FSM with registered outputs. The conv_start register is set
  // on the edge that begins a period, so the strobe lines up with cnt == 0.
  // On a period boundary the adc_done of the same cycle is honoured first,
  // which lets a conversion that finishes just in time avoid an overrun.
  // An overrun skips that period's conversion rather than queueing it.
  // The conversion that completes a burst moves the FSM to DRAIN on the
  // same edge; DRAIN waits for the last adc_done and then emits done.
  always_ff @(posedge clk_10m) begin
    if (rst) begin
      state_q       <= IDLE;
      burst_len_q   <= '0;
      issued_q      <= '0;
      sample_cnt_q  <= '0;
      outstanding_q <= 1'b0;
      conv_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      conv_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (ovr_clr) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            burst_len_q   <= burst_len;
            sample_cnt_q  <= '0;
            issued_q      <= BURST_W'(1);
            conv_start_q  <= 1'b1;
            outstanding_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= (burst_len == BURST_W'(1)) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (done_ack_d) begin
            outstanding_q <= 1'b0;
            sample_cnt_q  <= sample_cnt_d;
          end
          if (stop) begin
            state_q <= DRAIN;
          end else if (tick) begin
            if (outstanding_q && !done_ack_d) begin
              overrun_q <= 1'b1;
            end else begin
              conv_start_q  <= 1'b1;
              outstanding_q <= 1'b1;
              issued_q      <= issued_d;
              if ((burst_len_q != '0) && (issued_d == burst_len_q)) begin
                state_q <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (!outstanding_q || done_ack_d) begin
            if (done_ack_d) begin
              sample_cnt_q <= sample_cnt_d;
            end
            outstanding_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          outstanding_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign conv_start = conv_start_q;
  assign busy       = busy_q;
  assign sample_cnt = sample_cnt_q;
  assign overrun    = overrun_q;
  assign done       = done_q;

endmodule
